// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator, pixel enable from divided clock.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk_in,
    input  logic        rst_a,
    input  logic        pix_div,
    input  logic [11:0] rgb_in,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic [11:0] rgb_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pix_div_q;
    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_vis;
    logic       v_vis;
    logic       hs_act;
    logic       vs_act;
    logic       first_px;

    // Divider resets high, so the registered copy does too: no edge at reset.
    always_ff @(posedge clk_in or posedge rst_a) begin
        if (rst_a) begin
            pix_div_q <= 1'b1;
        end else begin
            pix_div_q <= pix_div;
        end
    end

    assign pix_en = pix_div & ~pix_div_q;

    always_ff @(posedge clk_in or posedge rst_a) begin
        if (rst_a) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        h_vis    = (h_cnt < H_VIS);
        v_vis    = (v_cnt < V_VIS);
        hs_act   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_act   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        first_px = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    // Outputs present the pre-advance counter values.
    always_ff @(posedge clk_in or posedge rst_a) begin
        if (rst_a) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                hsync       <= ~hs_act;
                vsync       <= ~vs_act;
                video_on    <= h_vis & v_vis;
                pixel_x     <= h_cnt;
                pixel_y     <= v_cnt;
                frame_start <= first_px;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] bar_rgb;
    logic        unused_rgb_in;

    assign unused_rgb_in = ^rgb_in;

    // 80-pixel bars selected by a compare chain instead of a divider.
    always_comb begin
        bar_rgb = 12'h000;
        if (h_cnt < 10'd80) begin
            bar_rgb = 12'hFFF;
        end else if (h_cnt < 10'd160) begin
            bar_rgb = 12'hFF0;
        end else if (h_cnt < 10'd240) begin
            bar_rgb = 12'h0FF;
        end else if (h_cnt < 10'd320) begin
            bar_rgb = 12'h0F0;
        end else if (h_cnt < 10'd400) begin
            bar_rgb = 12'hF0F;
        end else if (h_cnt < 10'd480) begin
            bar_rgb = 12'hF00;
        end else if (h_cnt < 10'd560) begin
            bar_rgb = 12'h00F;
        end else begin
            bar_rgb = 12'h000;
        end
    end

    always_ff @(posedge clk_in or posedge rst_a) begin
        if (rst_a) begin
            rgb_out <= 12'h000;
        end else if (pix_en) begin
            rgb_out <= (h_vis & v_vis) ? bar_rgb : 12'h000;
        end
    end
`else
    // Combinational so the renderer can answer the presented pixel in-cycle.
    assign rgb_out = video_on ? rgb_in : 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a shortened vertical frame.
// Expected outputs are modelled per cycle and popped by a monitor.
module tb_vga_timing_gen;

    localparam int HT = 800;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VV + VF + VS + VB;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } out_t;

    localparam out_t RST_OUT = '{hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0,
                                 x: 10'd0, y: 10'd0, rgb: 12'h000};

    logic        clk_in = 1'b0;
    logic        rst_a;
    logic        pix_div;
    logic [11:0] rgb_in;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic [11:0] rgb_out;

    vga_timing_gen #(
        .V_VISIBLE(VV),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB)
    ) dut (
        .clk_in     (clk_in),
        .rst_a      (rst_a),
        .pix_div    (pix_div),
        .rgb_in     (rgb_in),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_start(frame_start),
        .rgb_out    (rgb_out)
    );

    always #10 clk_in = ~clk_in;

    out_t act;
    assign act = {hsync, vsync, video_on, frame_start,
                  pixel_x, pixel_y, rgb_out};

    out_t sbq[$];
    out_t e;
    out_t exp_o;
    int   checks = 0;
    int   errors = 0;
    int   mh;
    int   mv;
    bit   mdq;
    int   cyc = 0;

    function automatic logic [11:0] bar_col(input int x);
        case (x / 80)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clk_in) begin
        #1;
        if (sbq.size() > 0) begin
            exp_o = sbq.pop_front();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got %h expected %h",
                         cyc, act, exp_o);
            end
        end
    end

    task automatic model_reset();
        mh  = 0;
        mv  = 0;
        mdq = 1'b1;
        e   = RST_OUT;
        sbq.delete();
    endtask

    task automatic tick(input logic div);
        @(negedge clk_in);
        pix_div = div;
        e.fs = 1'b0;
        if (div && !mdq) begin
            e.x   = 10'(mh);
            e.y   = 10'(mv);
            e.von = (mh < 640) && (mv < VV);
            e.hs  = !((mh >= 656) && (mh <= 751));
            e.vs  = !((mv >= VV + VF) && (mv <= VV + VF + VS - 1));
            e.fs  = (mh == 0) && (mv == 0);
`ifdef VGA_TEST_PATTERN_EN
            e.rgb = e.von ? bar_col(mh) : 12'h000;
`endif
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        mdq = div;
`ifndef VGA_TEST_PATTERN_EN
        e.rgb = e.von ? rgb_in : 12'h000;
`endif
        sbq.push_back(e);
        cyc++;
        @(posedge clk_in);
        #2;
    endtask

    task automatic run_to_x(input int tx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1700; i++) begin
            tick(!mdq);
            if (pixel_x == 10'(tx)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_a   = 1'b1;
        pix_div = 1'b1;
        rgb_in  = 12'h000;
        model_reset();
        repeat (3) @(posedge clk_in);
        #2;
        checks++;
        if (act !== RST_OUT) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", act, RST_OUT);
        end
        @(negedge clk_in);
        rst_a = 1'b0;
    endtask

    task automatic test_first_pixel();
        logic [25:0] got;
        logic [25:0] want;
        tick(1'b0);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL no_early_fs got %b expected 0", frame_start);
        end
        tick(1'b1);
        got  = {hsync, vsync, video_on, frame_start, pixel_x, pixel_y};
        want = {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL first_pixel got %h expected %h", got, want);
        end
        tick(1'b0);
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_width got %b expected 0", frame_start);
        end
    endtask

    task automatic test_line();
        int hs_low  = 0;
        int von_low = 0;
        int t0      = -1;
        int t1      = -1;
        logic [9:0] px = pixel_x;
        for (int i = 0; i < 3200; i++) begin
            tick(!mdq);
            if (i < 1600) begin
                if (!hsync) hs_low++;
                if (!video_on) von_low++;
            end
            if (pixel_x == 10'd0 && px != 10'd0) begin
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
            end
            px = pixel_x;
        end
        checks++;
        if (hs_low !== 192) begin
            errors++;
            $display("FAIL hsync_low_cycles got %0d expected 192", hs_low);
        end
        checks++;
        if (von_low !== 320) begin
            errors++;
            $display("FAIL blank_cycles got %0d expected 320", von_low);
        end
        checks++;
        if (t1 - t0 !== 1600) begin
            errors++;
            $display("FAIL line_period got %0d expected 1600", t1 - t0);
        end
    endtask

    task automatic test_rgb();
        int          tx[4]  = '{0, 85, 639, 700};
        logic [11:0] want[4];
        bit          done[4] = '{0, 0, 0, 0};
`ifdef VGA_TEST_PATTERN_EN
        want = '{12'hFFF, 12'hFF0, 12'h000, 12'h000};
`else
        want = '{12'hABC, 12'hABC, 12'hABC, 12'h000};
`endif
        rgb_in = 12'hABC;
        for (int i = 0; i < 1700; i++) begin
            tick(!mdq);
            for (int k = 0; k < 4; k++) begin
                if (!done[k] && pixel_x == 10'(tx[k])) begin
                    done[k] = 1'b1;
                    checks++;
                    if (rgb_out !== want[k]) begin
                        errors++;
                        $display("FAIL rgb_x%0d got %h expected %h",
                                 tx[k], rgb_out, want[k]);
                    end
                end
            end
        end
        checks++;
        if (done !== '{1, 1, 1, 1}) begin
            errors++;
            $display("FAIL rgb_coverage got %b%b%b%b expected 1111",
                     done[0], done[1], done[2], done[3]);
        end
    endtask

    task automatic test_hold();
        bit   ok;
        out_t held;
        int   fs_seen = 0;
        run_to_x(300, ok);
        if (!mdq) tick(1'b1);
        held = act;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1);
            if (frame_start) fs_seen++;
        end
        checks++;
        if (!ok || act !== held || fs_seen != 0) begin
            errors++;
            $display("FAIL hold got %h fs=%0d expected %h fs=0",
                     act, fs_seen, held);
        end
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (pixel_x !== held.x + 10'd1) begin
            errors++;
            $display("FAIL resume_x got %0d expected %0d",
                     pixel_x, held.x + 10'd1);
        end
    endtask

    task automatic test_frame();
        int         t0     = -1;
        int         t1     = -1;
        int         vs_low = 0;
        int         vs_bad = 0;
        logic [9:0] last_y = pixel_y;
        logic [9:0] wrap_y = '1;
        for (int i = 0; i < 2 * VT * 1600 + 400; i++) begin
            tick(!mdq);
            if (frame_start) begin
                if (t0 < 0) begin
                    t0 = cyc;
                end else begin
                    t1     = cyc;
                    wrap_y = last_y;
                    break;
                end
            end
            if (t0 >= 0 && !vsync) begin
                vs_low++;
                if (pixel_y < 10'(VV + VF) || pixel_y > 10'(VV + VF + VS - 1))
                    vs_bad++;
            end
            last_y = pixel_y;
        end
        checks++;
        if (t1 < 0 || t1 - t0 !== VT * 1600) begin
            errors++;
            $display("FAIL frame_period got %0d expected %0d",
                     t1 - t0, VT * 1600);
        end
        checks++;
        if (vs_low !== VS * 1600 || vs_bad !== 0) begin
            errors++;
            $display("FAIL vsync_rows got %0d bad=%0d expected %0d bad=0",
                     vs_low, vs_bad, VS * 1600);
        end
        checks++;
        if (wrap_y !== 10'(VT - 1)) begin
            errors++;
            $display("FAIL y_wrap got %0d expected %0d", wrap_y, VT - 1);
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic [22:0] got;
        run_to_x(700, ok);
        checks++;
        if (!ok || hsync !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_hsync got %b expected 0", hsync);
        end
        #3;
        rst_a   = 1'b1;
        pix_div = 1'b1;
        #1;
        checks++;
        if (act !== RST_OUT) begin
            errors++;
            $display("FAIL async_reset got %h expected %h", act, RST_OUT);
        end
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_a = 1'b0;
        tick(1'b0);
        tick(1'b1);
        got = {frame_start, video_on, hsync, pixel_x, pixel_y};
        checks++;
        if (got !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL restart_origin got %h expected %h",
                     got, {1'b1, 1'b1, 1'b1, 10'd0, 10'd0});
        end
        repeat (4) tick(!mdq);
    endtask

    initial begin
        rst_a   = 1'b1;
        pix_div = 1'b1;
        rgb_in  = 12'h000;
        test_reset();
        test_first_pixel();
        test_line();
        test_rgb();
        test_hold();
        test_frame();
        test_reset_mid();
        @(posedge clk_in);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA 640x480@60 Hz raster timing generator in the 50 MHz `clk_in` domain. It consumes the 25 MHz divided clock from the clock-divider stage as a level signal and edge-detects it into a one-cycle pixel enable. On each enable it advances horizontal and vertical counters and drives `hsync`, `vsync`, `video_on`, pixel coordinates and a frame-start strobe to the renderer and the VGA DAC pins.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk_in` in 1: 50 MHz system clock; all logic on its rising edge.
- `rst_a` in 1: asynchronous, active-high reset.
- `pix_div` in 1: divided pixel clock level, synchronous to `clk_in`.
- `rgb_in` in 12: renderer colour {R[3:0],G[3:0],B[3:0]} for the presented pixel.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `video_on` out 1: presented pixel is visible.
- `pixel_x` out 10: presented column.
- `pixel_y` out 10: presented row.
- `frame_start` out 1: one-`clk_in` pulse when pixel (0,0) is presented.
- `rgb_out` out 12: colour to DAC.

## Operation
- Edge detect: `pix_div_q` is registered from `pix_div`, and its reset value is 1. `pix_en = pix_div & ~pix_div_q`. This rule is fixed: the divider resets its output high, so no spurious edge occurs after reset.
- `H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK` (800). `V_TOTAL` is the same sum for vertical (525). Both must be ≤ 1024, since the counters are 10 bits.
- Counters `h_cnt` and `v_cnt` change only in cycles with `pix_en`.
  - On `pix_en`: `h_cnt` increments. At `H_TOTAL-1` it wraps to 0 and `v_cnt` increments.
  - `v_cnt` at `V_TOTAL-1` wraps to 0 at the same end of line.
- Presentation: in a `pix_en` cycle, the outputs register a decode of the *current* `(h_cnt, v_cnt)`. The counters advance in that same cycle.
  - `pixel_x = h_cnt`, `pixel_y = v_cnt`.
  - `video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)`.
  - `hsync = 0` iff `h_cnt` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - `vsync = 0` iff `v_cnt` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
  - `frame_start = 1` iff `h_cnt==0 && v_cnt==0`. In all other cycles it is 0, so the pulse is exactly one `clk_in` cycle.
- Outputs other than `frame_start` hold their values between `pix_en` cycles.
- `rgb_out` behaviour: see Configuration.

## Timing
- Reset values: `hsync=1`, `vsync=1`, `video_on=0`, `pixel_x=0`, `pixel_y=0`, `frame_start=0`, `rgb_out=0`, `h_cnt=0`, `v_cnt=0`, `pix_div_q=1`.
- Latency: outputs update on the `clk_in` edge that ends the `pix_en` cycle. The first `pix_en` after reset presents (0,0) with `frame_start=1` and `video_on=1`.
- With a 25 MHz `pix_div` (toggling every `clk_in`), `pix_en` occurs every 2nd cycle:
  - 1600 `clk_in` cycles per line.
  - 840 000 `clk_in` cycles per frame.
- `pix_div` held constant means no advance: all outputs freeze, and `frame_start` stays 0.
- Reset mid-frame asynchronously forces the reset values immediately. On release, counting restarts at (0,0).
- Frame wrap: the `pix_en` that presents (799,524) sets the counters to (0,0). The next `pix_en` presents (0,0) and pulses `frame_start`.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - `rgb_in` is ignored.
  - `rgb_out` is registered on `pix_en` alongside `video_on`.
  - Visible pixels get 8 vertical bars, each 80 px wide (x/80 by compare chain, no divider). Bar colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - Blanked pixels get 000.
- `VGA_TEST_PATTERN_EN` undefined: `rgb_out = video_on ? rgb_in : 12'h000`, combinational, so the renderer drives `rgb_in` from the presented `pixel_x`/`pixel_y` in the same cycle.

## Test plan
- Reset, then `pix_div` toggling every cycle: the first `pix_en` gives `pixel_x=0`, `pixel_y=0`, `frame_start=1` for 1 cycle, `video_on=1`, `hsync=1`, `vsync=1`.
- Run one line: `hsync=0` for exactly 96 presented pixels (x 656..751), i.e. 192 `clk_in` cycles. `video_on=0` for x ≥ 640. The line period is 1600 `clk_in` cycles.
- Run one frame: `vsync=0` only on rows 490–491. `frame_start` pulses are exactly 840 000 cycles apart. `pixel_y` wraps from 524 to 0.
- Hold `pix_div=1` for 100 cycles mid-line: all outputs are unchanged and `frame_start=0`. Resume toggling: x continues from the held value +1.
- Assert `rst_a` at x=700, y=300 (`hsync=0`): `hsync` goes to 1 immediately and all outputs take their reset values. After release, the first `pix_en` presents (0,0).
- Without the macro, `rgb_in=12'hABC`: `rgb_out=ABC` while `video_on=1` and `000` while blanked. With the macro: x=0 → FFF, x=85 → FF0, x=639 → 000, blanking → 000.
